// File: rtl/spi_pkg.sv
// Shared definitions for the SPI link: word width, idle/default levels and
// the peripheral frame-state encoding.
package spi_pkg;

  localparam int SPI_WIDTH = 8;

  localparam logic [SPI_WIDTH-1:0] SPI_DEFAULT_TX = 8'hFF;
  localparam logic                 SPI_MISO_IDLE  = 1'b1;

  typedef enum logic {
    SPI_IDLE,
    SPI_SHIFT
  } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer for one asynchronous input, followed by a delay
// flop that turns level changes into single-cycle rise/fall strobes.
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              dly;

  // Presetting to the line's idle level keeps reset release from faking an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {STAGES{RESET_VAL}};
      dly   <= RESET_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      dly   <= chain[STAGES-1];
    end
  end

  assign level = chain[STAGES-1];
  assign rise  = level & ~dly;
  assign fall  = ~level & dly;

endmodule

// File: rtl/spi_peripheral.sv
// Mode 0, MSB-first SPI target: oversamples SCK/CS_n/MOSI with clk, shifts
// words in and out, and offers a one-deep transmit holding register.
module spi_peripheral
  import spi_pkg::*;
#(
  parameter int               WIDTH       = SPI_WIDTH,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] DEFAULT_TX  = SPI_DEFAULT_TX,
  parameter logic             MISO_IDLE   = SPI_MISO_IDLE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             SCK,
  input  logic             CS_n,
  input  logic             MOSI,
  output logic             MISO,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             busy,
  output logic             tx_underrun,
  output logic             frame_abort
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  spi_state_t state, state_next;

  logic cs_level, cs_rise, cs_fall;
  logic sck_level, sck_rise, sck_fall;
  logic unused_sck_level;
  logic [SYNC_STAGES-1:0] mosi_chain;
  logic mosi_s;

  logic start_frame, end_frame, rx_sample, tx_load, tx_shift_en;

  logic [WIDTH-1:0] hold_reg;
  logic             hold_full;
  logic [WIDTH-1:0] tx_shift;
  logic [WIDTH-2:0] rx_shift;
  logic [WIDTH-1:0] rx_next;
  logic             rx_pend;
  logic [CNT_W-1:0] bit_cnt;
  logic             word_end;
  logic             word_done;

  spi_sync_edge #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_cs_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (CS_n),
    .level (cs_level),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  spi_sync_edge #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b0)
  ) u_sck_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (SCK),
    .level (sck_level),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  assign unused_sck_level = sck_level;

  // MOSI has the same depth as SCK so mosi_s lines up with the sck_rise strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mosi_chain <= '1;
    end else begin
      mosi_chain <= {mosi_chain[SYNC_STAGES-2:0], MOSI};
    end
  end

  assign mosi_s = mosi_chain[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SPI_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // cs_rise wins over SCK strobes; a SCK edge coinciding with cs_fall is dropped.
  always_comb begin
    state_next  = state;
    start_frame = 1'b0;
    end_frame   = 1'b0;
    rx_sample   = 1'b0;
    tx_load     = 1'b0;
    tx_shift_en = 1'b0;
    case (state)
      SPI_IDLE: begin
        if (cs_fall) begin
          state_next  = SPI_SHIFT;
          start_frame = 1'b1;
          tx_load     = 1'b1;
        end
      end
      SPI_SHIFT: begin
        if (cs_rise) begin
          state_next = SPI_IDLE;
          end_frame  = 1'b1;
        end else begin
          rx_sample = sck_rise;
          if (sck_fall) begin
            tx_load     = word_done;
            tx_shift_en = ~word_done;
          end
        end
      end
      default: begin
        state_next = SPI_IDLE;
      end
    endcase
  end

  // Consume requires full and write requires empty, so the two never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_reg  <= '0;
      hold_full <= 1'b0;
    end else if (tx_load && hold_full) begin
      hold_full <= 1'b0;
    end else if (tx_valid && !hold_full) begin
      hold_reg  <= tx_data;
      hold_full <= 1'b1;
    end
  end

  assign tx_ready = ~hold_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shift    <= '1;
      tx_underrun <= 1'b0;
    end else begin
      tx_underrun <= 1'b0;
      if (tx_load) begin
        if (hold_full) begin
          tx_shift <= hold_reg;
        end else begin
          tx_shift    <= DEFAULT_TX;
          tx_underrun <= 1'b1;
        end
      end else if (tx_shift_en) begin
        tx_shift <= {tx_shift[WIDTH-2:0], 1'b1};
      end
    end
  end

  assign rx_next  = {rx_shift, mosi_s};
  assign word_end = (bit_cnt == LAST_BIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_shift <= '0;
      rx_data  <= '0;
      rx_pend  <= 1'b0;
      rx_valid <= 1'b0;
    end else begin
      rx_pend  <= 1'b0;
      rx_valid <= rx_pend;
      if (rx_sample) begin
        rx_shift <= rx_next[WIDTH-2:0];
        if (word_end) begin
          rx_data <= rx_next;
          rx_pend <= 1'b1;
        end
      end
    end
  end

  // word_done marks that the next SCK fall must load a fresh word, not shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt     <= '0;
      word_done   <= 1'b0;
      busy        <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      frame_abort <= 1'b0;
      if (start_frame) begin
        bit_cnt   <= '0;
        word_done <= 1'b0;
        busy      <= 1'b1;
      end else if (end_frame) begin
        frame_abort <= (bit_cnt != '0);
        bit_cnt     <= '0;
        word_done   <= 1'b0;
        busy        <= 1'b0;
      end else if (rx_sample) begin
        if (word_end) begin
          bit_cnt   <= '0;
          word_done <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
      end else if (tx_load) begin
        word_done <= 1'b0;
      end
    end
  end

  assign MISO = cs_level ? MISO_IDLE : tx_shift[WIDTH-1];

endmodule

// File: tb/tb_spi_peripheral.sv
// Self-checking bench for spi_peripheral: a bit-banged SPI controller, a TX
// feeder, and a word-level reference model of what each frame must produce.
module tb_spi_peripheral;

  localparam logic [7:0] DEF_TX = 8'hFF;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       SCK, CS_n, MOSI;
  logic       MISO;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       tx_underrun;
  logic       frame_abort;

  int errors;
  int checks;

  logic [7:0] tx_q[$];
  logic [7:0] model_hold[$];
  logic [7:0] mosi_q[$];
  logic [7:0] miso_q[$];
  logic [7:0] rx_log[$];
  int         ur_cnt = 0;
  int         ab_cnt = 0;

  spi_peripheral dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .SCK         (SCK),
    .CS_n        (CS_n),
    .MOSI        (MOSI),
    .MISO        (MISO),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .busy        (busy),
    .tx_underrun (tx_underrun),
    .frame_abort (frame_abort)
  );

  always #5 clk = ~clk;

  // Pulse monitor, sampled on the falling edge so each one-cycle pulse is seen once.
  initial begin
    forever begin
      @(negedge clk);
      if (rx_valid === 1'b1) rx_log.push_back(rx_data);
      if (tx_underrun === 1'b1) ur_cnt++;
      if (frame_abort === 1'b1) ab_cnt++;
    end
  end

  // TX feeder: presents queued words one at a time whenever tx_ready is high.
  initial begin
    tx_valid = 1'b0;
    tx_data  = '0;
    forever begin
      @(negedge clk);
      if (tx_valid && !tx_ready) begin
        tx_q.delete(0);
        tx_valid = 1'b0;
      end else if (!tx_valid && tx_q.size() != 0 && tx_ready && rst_n) begin
        tx_data  = tx_q[0];
        tx_valid = 1'b1;
      end
    end
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic half_sck();
    repeat (4) @(posedge clk);
    #2;
  endtask

  task automatic queue_tx(input logic [7:0] w);
    tx_q.push_back(w);
    model_hold.push_back(w);
    repeat (4) @(posedge clk);
    #2;
  endtask

  // One frame of nbits; CS_n rises together with the final SCK fall.
  task automatic spi_frame(input string tag, input int nbits);
    logic [7:0]  cur;
    logic [7:0]  exp_w;
    logic [31:0] obs;
    int ur0, ab0, rx0, loads, exp_ur, full_words;
    ur0 = ur_cnt;
    ab0 = ab_cnt;
    rx0 = rx_log.size();
    miso_q.delete();
    cur = '0;
    CS_n = 1'b0;
    half_sck();
    half_sck();
    for (int i = 0; i < nbits; i++) begin
      MOSI = mosi_q[i/8][7-(i%8)];
      half_sck();
      cur = {cur[6:0], MISO};
      SCK = 1'b1;
      if (i % 8 == 7) miso_q.push_back(cur);
      half_sck();
      if (i == 0) check_output({tag, ".busy_mid"}, 32'(busy), 32'd1);
      SCK = 1'b0;
      if (i == nbits - 1) CS_n = 1'b1;
    end
    repeat (8) @(posedge clk);
    #2;

    full_words = nbits / 8;
    loads      = 1 + (nbits - 1) / 8;
    exp_ur     = 0;
    for (int l = 0; l < loads; l++) begin
      if (model_hold.size() != 0) begin
        exp_w = model_hold.pop_front();
      end else begin
        exp_w = DEF_TX;
        exp_ur++;
      end
      if (l < full_words) check_output({tag, ".miso_word"}, 32'(miso_q[l]), 32'(exp_w));
    end
    check_output({tag, ".underruns"}, 32'(ur_cnt - ur0), 32'(exp_ur));
    check_output({tag, ".aborts"}, 32'(ab_cnt - ab0), (nbits % 8 != 0) ? 32'd1 : 32'd0);
    check_output({tag, ".rx_count"}, 32'(rx_log.size() - rx0), 32'(full_words));
    for (int w = 0; w < full_words; w++) begin
      obs = (rx0 + w < rx_log.size()) ? 32'(rx_log[rx0+w]) : 'x;
      check_output({tag, ".rx_word"}, obs, 32'(mosi_q[w]));
    end
    check_output({tag, ".busy_end"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int nwords, nbits, k;
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    CS_n   = 1'b0;
    SCK    = 1'b0;
    MOSI   = 1'b1;

    $display("[TB] reset with SCK toggling and CS_n low");
    for (int i = 0; i < 3; i++) begin
      #7 SCK = ~SCK;
      @(negedge clk);
      check_output("reset.miso", 32'(MISO), 32'd1);
      check_output("reset.tx_ready", 32'(tx_ready), 32'd1);
      check_output("reset.rx_valid", 32'(rx_valid), 32'd0);
      check_output("reset.busy", 32'(busy), 32'd0);
    end
    check_output("reset.rx_data", 32'(rx_data), 32'd0);
    check_output("reset.pulses", 32'({tx_underrun, frame_abort}), 32'd0);
    SCK  = 1'b0;
    CS_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #2;
    check_output("release.busy", 32'(busy), 32'd0);
    check_output("release.underruns", 32'(ur_cnt), 32'd0);

    $display("[TB] single word");
    queue_tx(8'hA5);
    mosi_q = '{8'h3C};
    spi_frame("single", 8);

    $display("[TB] back-to-back words");
    queue_tx(8'h12);
    queue_tx(8'h34);
    mosi_q = '{8'($urandom), 8'($urandom)};
    spi_frame("b2b", 16);

    $display("[TB] underrun");
    mosi_q = '{8'($urandom), 8'($urandom)};
    spi_frame("underrun", 16);

    $display("[TB] abort after 5 bits, then fresh frame");
    mosi_q = '{8'($urandom)};
    spi_frame("abort", 5);
    mosi_q = '{8'h81};
    spi_frame("after_abort", 8);

    $display("[TB] random frames");
    for (int f = 0; f < 5; f++) begin
      k      = $urandom_range(0, 3);
      nwords = $urandom_range(1, 3);
      nbits  = nwords * 8;
      if ($urandom_range(0, 3) == 0) nbits = nbits - $urandom_range(1, 7);
      for (int j = 0; j < k; j++) queue_tx(8'($urandom));
      mosi_q.delete();
      for (int j = 0; j < nwords; j++) mosi_q.push_back(8'($urandom));
      spi_frame("random", nbits);
    end
    for (int d = 0; d < 8 && model_hold.size() != 0; d++) begin
      mosi_q = '{8'($urandom)};
      spi_frame("drain", 8);
    end

    $display("[TB] async reset mid-word");
    queue_tx(8'hC3);
    queue_tx(8'h99);
    mosi_q = '{8'($urandom)};
    CS_n = 1'b0;
    half_sck();
    half_sck();
    for (int i = 0; i < 3; i++) begin
      MOSI = mosi_q[0][7-i];
      half_sck();
      SCK = 1'b1;
      half_sck();
      SCK = 1'b0;
    end
    for (int t = 0; t < 50 && tx_q.size() != 0; t++) @(posedge clk);
    #2;
    check_output("midreset.feed_drained", 32'(tx_q.size()), 32'd0);
    check_output("midreset.hold_full", 32'(tx_ready), 32'd0);
    check_output("midreset.busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_output("midreset.miso", 32'(MISO), 32'd1);
    check_output("midreset.busy", 32'(busy), 32'd0);
    check_output("midreset.tx_ready", 32'(tx_ready), 32'd1);
    check_output("midreset.rx_valid", 32'(rx_valid), 32'd0);
    check_output("midreset.rx_data", 32'(rx_data), 32'd0);
    model_hold.delete();
    CS_n = 1'b1;
    SCK  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    mosi_q = '{8'h5A};
    spi_frame("post_reset", 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
